// File: rtl/pcileech_bar_rsp_packer.sv
// Packs DWORD read replies from the BAR blocks into 64-bit beats (pairing equal contexts)
// and buffers them in a show-ahead FIFO toward the completion-TLP generator.
module pcileech_bar_rsp_packer #(
  parameter int DEPTH         = 16,
  parameter int FLUSH_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [87:0]              in_ctx,
  input  logic [31:0]              in_data,
  input  logic                     in_valid,
  output logic [87:0]              out_ctx,
  output logic [63:0]              out_data,
  output logic [1:0]               out_dwen,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            BW       = 88 + 2 + 64;
  localparam logic [7:0]    TMO_LAST = 8'(FLUSH_TIMEOUT - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t       r_state, w_state_nxt;
  logic [7:0]   r_timer, w_timer_nxt;
  logic [87:0]  r_hold_ctx;
  logic [31:0]  r_hold_data;
  logic         w_latch;
  logic         w_push;
  logic [87:0]  w_push_ctx;
  logic [63:0]  w_push_data;
  logic [1:0]   w_push_dwen;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    w_push_ctx  = r_hold_ctx;
    w_push_data = {32'h0, r_hold_data};
    w_push_dwen = 2'b01;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_latch     = 1'b1;
          w_timer_nxt = 8'd0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (in_valid) begin
          w_push = 1'b1;
          if (in_ctx == r_hold_ctx) begin
            w_push_data = {in_data, r_hold_data};
            w_push_dwen = 2'b11;
            w_state_nxt = S_IDLE;
          end else begin
            w_latch     = 1'b1;
            w_timer_nxt = 8'd0;
          end
        end else if (r_timer == TMO_LAST) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_hold_ctx  <= in_ctx;
      r_hold_data <= in_data;
    end
  end

  // ---- stage p0: registered push beat ----
  logic         r_beat_vld_p0;
  logic [87:0]  r_beat_ctx_p0;
  logic [63:0]  r_beat_data_p0;
  logic [1:0]   r_beat_dwen_p0;

  always_ff @(posedge clk) begin
    if (rst) r_beat_vld_p0 <= 1'b0;
    else     r_beat_vld_p0 <= w_push;
  end

  always_ff @(posedge clk) begin
    r_beat_ctx_p0  <= w_push_ctx;
    r_beat_data_p0 <= w_push_data;
    r_beat_dwen_p0 <= w_push_dwen;
  end

  // ---- FIFO: write of p0 beat, show-ahead read ----
  logic [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_fill;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;
  logic          w_full, w_pop, w_wr_en, w_drop;
  logic [BW-1:0] w_head;

  assign w_full  = (r_fill == FULL_LVL);
  assign w_pop   = out_valid && out_ready;
  assign w_wr_en = r_beat_vld_p0 && (!w_full || w_pop);
  assign w_drop  = r_beat_vld_p0 && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {r_beat_ctx_p0, r_beat_dwen_p0, r_beat_data_p0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_fill <= r_fill + (AW + 1)'(1);
        2'b01:   r_fill <= r_fill - (AW + 1)'(1);
        default: r_fill <= r_fill;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= sat_inc16(r_drop_cnt);
      end
    end
  end

  // Memory contents are never reset, so the head is masked to zero while empty.
  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = (r_fill != '0);
  assign out_ctx    = out_valid ? w_head[BW-1:66] : 88'h0;
  assign out_dwen   = out_valid ? w_head[65:64]   : 2'b00;
  assign out_data   = out_valid ? w_head[63:0]    : 64'h0;
  assign fill_level = r_fill;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;

endmodule
